// File: rtl/alu_issue_ctrl_if.sv
// Command, response and ALU-port bundle for alu_issue_ctrl.
// slave  : the issue controller (consumes commands, produces responses, drives the ALU inputs)
// master : the surrounding decode / writeback / ALU environment
interface alu_issue_ctrl_if;
  // decode -> controller
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_op;
  logic [15:0] cmd_a;
  logic [15:0] cmd_b;
  logic [3:0]  cmd_tag;

  // controller <-> combinational ALU
  logic [15:0] alu_x;
  logic [15:0] alu_y;
  logic [2:0]  alu_opcode;
  logic [15:0] alu_out;
  logic        alu_cout;
  logic        alu_v;
  logic        alu_lt;
  logic        alu_eq;
  logic        alu_gt;

  // controller -> writeback
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_data;
  logic [4:0]  rsp_flags;
  logic [3:0]  rsp_tag;
  logic        rsp_err;

  modport slave (
    input  cmd_valid, cmd_op, cmd_a, cmd_b, cmd_tag,
    input  alu_out, alu_cout, alu_v, alu_lt, alu_eq, alu_gt,
    input  rsp_ready,
    output cmd_ready, alu_x, alu_y, alu_opcode,
    output rsp_valid, rsp_data, rsp_flags, rsp_tag, rsp_err
  );

  modport master (
    output cmd_valid, cmd_op, cmd_a, cmd_b, cmd_tag,
    output alu_out, alu_cout, alu_v, alu_lt, alu_eq, alu_gt,
    output rsp_ready,
    input  cmd_ready, alu_x, alu_y, alu_opcode,
    input  rsp_valid, rsp_data, rsp_flags, rsp_tag, rsp_err
  );
endinterface

// File: rtl/alu_issue_ctrl.sv
// Issue controller for the 16-bit combinational ALU.
// Buffers decode commands in a DEPTH-entry FIFO, drives the ALU from the FIFO
// head and captures result/flags into a valid/ready response register.
// Optional build macro: ALU_OVF_TRAP_EN (ADD/SUB overflow -> error response,
// sticky trap that blocks further commands until reset).
//
// state  | meaning
// -------+---------------------------------------------------
// IDLE   | FIFO empty, no response held
// RUN    | issuing commands or draining the response register
// STALL  | response held and blocked, FIFO head waiting
module alu_issue_ctrl #(
  parameter int DEPTH = 2
) (
  input logic             i_clk,
  input logic             i_rst_n,
  alu_issue_ctrl_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  localparam logic [2:0] OP_AND = 3'd0;
  localparam logic [2:0] OP_OR  = 3'd1;
  localparam logic [2:0] OP_ADD = 3'd2;
  localparam logic [2:0] OP_SUB = 3'd3;
  localparam logic [2:0] OP_SLT = 3'd4;

  localparam logic [2:0] AL_AND = 3'b000;
  localparam logic [2:0] AL_OR  = 3'b001;
  localparam logic [2:0] AL_ADD = 3'b010;
  localparam logic [2:0] AL_SUB = 3'b110;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_STALL} state_t;

  typedef struct packed {
    logic [2:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [3:0]  tag;
  } cmd_t;

  logic [1:0]    r_rst_sync;
  logic          w_rst_n;

  cmd_t          r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic [CW-1:0] w_count_nxt;

  state_t        r_state;
  logic          r_cmd_ready;
  logic          r_rsp_valid;
  logic [15:0]   r_rsp_data;
  logic [4:0]    r_rsp_flags;
  logic [3:0]    r_rsp_tag;
  logic          r_rsp_err;

  cmd_t          w_cmd_in;
  cmd_t          w_head;
  logic          w_head_valid;
  logic          w_legal;
  logic          w_push;
  logic          w_issue;
  logic          w_rsp_valid_nxt;
  logic          w_trap_nxt;

  logic [15:0]   w_alu_x;
  logic [15:0]   w_alu_y;
  logic [2:0]    w_alu_op;
  logic [15:0]   w_rsp_data;
  logic [4:0]    w_rsp_flags;
  logic          w_rsp_err;

  // Reset asserts asynchronously, releases on the second clock edge afterwards.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_rst_sync <= 2'b00;
    else          r_rst_sync <= {r_rst_sync[0], 1'b1};
  end
  assign w_rst_n = r_rst_sync[1];

  assign w_cmd_in     = {bus.cmd_op, bus.cmd_a, bus.cmd_b, bus.cmd_tag};
  assign w_head       = r_mem[r_rd_ptr];
  assign w_head_valid = (r_count != '0);
  assign w_legal      = (w_head.op <= OP_SLT);

  // cmd_ready is a register derived from the occupancy, so a full FIFO refuses
  // a write even when an issue frees a slot on the same edge.
  assign w_push  = bus.cmd_valid && r_cmd_ready;
  assign w_issue = w_head_valid && (!r_rsp_valid || bus.rsp_ready);
  assign w_count_nxt     = r_count + CW'(w_push) - CW'(w_issue);
  assign w_rsp_valid_nxt = w_issue || (r_rsp_valid && !bus.rsp_ready);

`ifdef ALU_OVF_TRAP_EN
  logic r_trap;
  logic w_ovf;

  assign w_ovf = w_legal && ((w_head.op == OP_ADD) || (w_head.op == OP_SUB)) && bus.alu_v;

  // Sticky overflow trap; only reset clears it.
  always_ff @(posedge i_clk or negedge w_rst_n) begin
    if (!w_rst_n)              r_trap <= 1'b0;
    else if (w_issue && w_ovf) r_trap <= 1'b1;
  end
  assign w_trap_nxt = r_trap || (w_issue && w_ovf);
`else
  assign w_trap_nxt = 1'b0;
`endif

  // Command storage; contents are only meaningful while counted as occupied.
  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= w_cmd_in;
  end

  // FIFO pointers and occupancy; pointers wrap naturally at DEPTH.
  always_ff @(posedge i_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push)  r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_issue) r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= w_count_nxt;
    end
  end

  // ALU operands and opcode straight from the FIFO head; all zero when empty.
  always_comb begin
    w_alu_x  = '0;
    w_alu_y  = '0;
    w_alu_op = AL_AND;
    if (w_head_valid) begin
      w_alu_x = w_head.a;
      w_alu_y = w_head.b;
      case (w_head.op)
        OP_AND:         w_alu_op = AL_AND;
        OP_OR:          w_alu_op = AL_OR;
        OP_ADD:         w_alu_op = AL_ADD;
        OP_SUB, OP_SLT: w_alu_op = AL_SUB;
        default:        w_alu_op = AL_AND;
      endcase
    end
  end

  // Response value for the head command: SLT reduces to the lt flag, illegal
  // ops ignore the ALU entirely.
  always_comb begin
    w_rsp_data  = bus.alu_out;
    w_rsp_flags = {bus.alu_v, bus.alu_cout, bus.alu_lt, bus.alu_eq, bus.alu_gt};
    w_rsp_err   = 1'b0;
    if (!w_legal) begin
      w_rsp_data  = '0;
      w_rsp_flags = '0;
      w_rsp_err   = 1'b1;
    end else if (w_head.op == OP_SLT) begin
      w_rsp_data = {15'b0, bus.alu_lt};
    end
`ifdef ALU_OVF_TRAP_EN
    if (w_ovf) begin
      w_rsp_data = '0;
      w_rsp_err  = 1'b1;
    end
`endif
  end

  // Sequencing FSM with the registered cmd_ready and response outputs.
  always_ff @(posedge i_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state     <= S_IDLE;
      r_cmd_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_flags <= '0;
      r_rsp_tag   <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      r_cmd_ready <= (w_count_nxt != FULL) && !w_trap_nxt;

      if (w_issue) begin
        r_rsp_valid <= 1'b1;
        r_rsp_data  <= w_rsp_data;
        r_rsp_flags <= w_rsp_flags;
        r_rsp_tag   <= w_head.tag;
        r_rsp_err   <= w_rsp_err;
      end else if (bus.rsp_ready) begin
        r_rsp_valid <= 1'b0;
      end

      case (r_state)
        S_IDLE: begin
          if (w_push) r_state <= S_RUN;
        end
        S_RUN: begin
          if (r_rsp_valid && !bus.rsp_ready && w_head_valid)
            r_state <= S_STALL;
          else if ((w_count_nxt == '0) && !w_rsp_valid_nxt)
            r_state <= S_IDLE;
        end
        S_STALL: begin
          if (bus.rsp_ready) r_state <= S_RUN;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.cmd_ready  = r_cmd_ready;
  assign bus.alu_x      = w_alu_x;
  assign bus.alu_y      = w_alu_y;
  assign bus.alu_opcode = w_alu_op;
  assign bus.rsp_valid  = r_rsp_valid;
  assign bus.rsp_data   = r_rsp_data;
  assign bus.rsp_flags  = r_rsp_flags;
  assign bus.rsp_tag    = r_rsp_tag;
  assign bus.rsp_err    = r_rsp_err;
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Testbench for alu_issue_ctrl: models the combinational ALU, drives directed
// and random command/response traffic and compares every cycle against a
// queue-based reference of the controller's behaviour.
module tb_alu_issue_ctrl;
  localparam int DEPTH = 2;

  localparam logic [2:0] OP_AND = 3'd0;
  localparam logic [2:0] OP_OR  = 3'd1;
  localparam logic [2:0] OP_ADD = 3'd2;
  localparam logic [2:0] OP_SUB = 3'd3;
  localparam logic [2:0] OP_SLT = 3'd4;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  alu_issue_ctrl_if bus();

  alu_issue_ctrl #(.DEPTH(DEPTH)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  // Combinational ALU: bit-level adder, signed compare flags.
  logic [16:0] alu_s;
  always_comb begin
    alu_s        = '0;
    bus.alu_out  = '0;
    bus.alu_cout = 1'b0;
    bus.alu_v    = 1'b0;
    case (bus.alu_opcode)
      3'b000: bus.alu_out = bus.alu_x & bus.alu_y;
      3'b001: bus.alu_out = bus.alu_x | bus.alu_y;
      3'b010: begin
        alu_s        = {1'b0, bus.alu_x} + {1'b0, bus.alu_y};
        bus.alu_out  = alu_s[15:0];
        bus.alu_cout = alu_s[16];
        bus.alu_v    = (bus.alu_x[15] == bus.alu_y[15]) && (alu_s[15] != bus.alu_x[15]);
      end
      3'b110: begin
        alu_s        = {1'b0, bus.alu_x} + {1'b0, ~bus.alu_y} + 17'd1;
        bus.alu_out  = alu_s[15:0];
        bus.alu_cout = alu_s[16];
        bus.alu_v    = (bus.alu_x[15] != bus.alu_y[15]) && (alu_s[15] != bus.alu_x[15]);
      end
      default: ;
    endcase
    bus.alu_lt = $signed(bus.alu_x) <  $signed(bus.alu_y);
    bus.alu_eq = bus.alu_x == bus.alu_y;
    bus.alu_gt = $signed(bus.alu_x) >  $signed(bus.alu_y);
  end

  typedef struct {
    logic [2:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [3:0]  tag;
  } cmd_s;

  // Reference model state: pending commands and the one held response.
  cmd_s        fq[$];
  bit          rs_valid;
  logic [15:0] rs_data;
  logic [4:0]  rs_flags;
  logic [3:0]  rs_tag;
  bit          rs_err;
  bit          m_trap;

  int n_cmp = 0;
  int n_mis = 0;

  logic [15:0] corner [4];

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  // Response for a command from integer arithmetic on the operands.
  function automatic void model_rsp(input cmd_s c);
    int ua, ub, sa, sb, r;
    bit lt, eq, gt, cout, v;
    logic [15:0] d;
    ua = int'(c.a);
    ub = int'(c.b);
    sa = int'($signed(c.a));
    sb = int'($signed(c.b));
    lt = sa < sb;
    eq = sa == sb;
    gt = sa > sb;
    cout = 1'b0;
    v = 1'b0;
    d = '0;
    rs_err = 1'b0;
    case (c.op)
      OP_AND: d = c.a & c.b;
      OP_OR:  d = c.a | c.b;
      OP_ADD: begin
        r = sa + sb;
        v = (r > 32767) || (r < -32768);
        cout = (ua + ub) > 65535;
        d = 16'(ua + ub);
      end
      OP_SUB, OP_SLT: begin
        r = sa - sb;
        v = (r > 32767) || (r < -32768);
        cout = ua >= ub;
        d = 16'(ua - ub);
        if (c.op == OP_SLT) d = {15'b0, lt};
      end
      default: begin
        lt = 0; eq = 0; gt = 0;
        rs_err = 1'b1;
      end
    endcase
`ifdef ALU_OVF_TRAP_EN
    if (((c.op == OP_ADD) || (c.op == OP_SUB)) && v) begin
      d = '0;
      rs_err = 1'b1;
      m_trap = 1'b1;
    end
`endif
    rs_valid = 1'b1;
    rs_data  = d;
    rs_flags = {v, cout, lt, eq, gt};
    rs_tag   = c.tag;
  endfunction

  function automatic logic [2:0] exp_opcode(input logic [2:0] op);
    case (op)
      OP_AND: return 3'b000;
      OP_OR:  return 3'b001;
      OP_ADD: return 3'b010;
      OP_SUB, OP_SLT: return 3'b110;
      default: return 3'b000;
    endcase
  endfunction

  // One clock cycle: drive inputs, compare outputs with the model, advance both.
  task automatic cycle(input bit v, input logic [2:0] op, input logic [15:0] a,
                       input logic [15:0] b, input logic [3:0] tag, input bit rr);
    bit exp_ready, issue, accept;
    cmd_s c;
    bus.cmd_valid = v;
    bus.cmd_op    = op;
    bus.cmd_a     = a;
    bus.cmd_b     = b;
    bus.cmd_tag   = tag;
    bus.rsp_ready = rr;
    #1;
    exp_ready = (fq.size() < DEPTH) && !m_trap;
    chk("cmd_ready", 32'(bus.cmd_ready), 32'(exp_ready));
    chk("rsp_valid", 32'(bus.rsp_valid), 32'(rs_valid));
    if (rs_valid) begin
      chk("rsp_data",  32'(bus.rsp_data),  32'(rs_data));
      chk("rsp_flags", 32'(bus.rsp_flags), 32'(rs_flags));
      chk("rsp_tag",   32'(bus.rsp_tag),   32'(rs_tag));
      chk("rsp_err",   32'(bus.rsp_err),   32'(rs_err));
    end
    if (fq.size() > 0) begin
      chk("alu_x",      32'(bus.alu_x),      32'(fq[0].a));
      chk("alu_y",      32'(bus.alu_y),      32'(fq[0].b));
      chk("alu_opcode", 32'(bus.alu_opcode), 32'(exp_opcode(fq[0].op)));
    end else begin
      chk("alu_x_idle",  32'(bus.alu_x),      32'h0);
      chk("alu_op_idle", 32'(bus.alu_opcode), 32'h0);
    end
    issue  = (fq.size() > 0) && (!rs_valid || rr);
    accept = v && exp_ready;
    c.op = op; c.a = a; c.b = b; c.tag = tag;
    @(posedge clk);
    if (issue)   model_rsp(fq.pop_front());
    else if (rr) rs_valid = 1'b0;
    if (accept)  fq.push_back(c);
    #1;
  endtask

  task automatic idle(input int n, input bit rr);
    for (int i = 0; i < n; i++) cycle(1'b0, 3'd0, 16'h0, 16'h0, 4'h0, rr);
  endtask

  task automatic chk_reset(input string pfx);
    chk({pfx, "_cmd_ready"},  32'(bus.cmd_ready),  32'h1);
    chk({pfx, "_rsp_valid"},  32'(bus.rsp_valid),  32'h0);
    chk({pfx, "_rsp_data"},   32'(bus.rsp_data),   32'h0);
    chk({pfx, "_rsp_flags"},  32'(bus.rsp_flags),  32'h0);
    chk({pfx, "_rsp_tag"},    32'(bus.rsp_tag),    32'h0);
    chk({pfx, "_rsp_err"},    32'(bus.rsp_err),    32'h0);
    chk({pfx, "_alu_x"},      32'(bus.alu_x),      32'h0);
    chk({pfx, "_alu_y"},      32'(bus.alu_y),      32'h0);
    chk({pfx, "_alu_opcode"}, 32'(bus.alu_opcode), 32'h0);
  endtask

  task automatic model_clear();
    fq.delete();
    rs_valid = 1'b0;
    rs_err   = 1'b0;
    m_trap   = 1'b0;
  endtask

  function automatic logic [15:0] pick_operand();
    if ($urandom_range(0, 3) == 0) return corner[$urandom_range(0, 3)];
    return 16'($urandom);
  endfunction

  initial begin
    bit          rv, rr;
    logic [2:0]  rop;
    logic [15:0] ra, rb;

    corner[0] = 16'h0000;
    corner[1] = 16'h7FFF;
    corner[2] = 16'h8000;
    corner[3] = 16'hFFFF;
    model_clear();
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = '0;
    bus.cmd_a     = '0;
    bus.cmd_b     = '0;
    bus.cmd_tag   = '0;
    bus.rsp_ready = 1'b1;

    // power-on reset held across several edges
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset("por");
    rst_n = 1'b1;
    idle(4, 1'b1);

    // ADD, latency and flags
    cycle(1'b1, OP_ADD, 16'h0005, 16'h0003, 4'd1, 1'b1);
    idle(3, 1'b1);

    // SUB with signed overflow
    cycle(1'b1, OP_SUB, 16'h7FFF, 16'hFFFF, 4'd2, 1'b1);
    idle(2, 1'b1);

    // SLT, AND, OR back to back
    cycle(1'b1, OP_SLT, 16'h0002, 16'h0009, 4'd3, 1'b1);
    cycle(1'b1, OP_AND, 16'hF0F0, 16'h0FF0, 4'd4, 1'b1);
    cycle(1'b1, OP_OR,  16'hF0F0, 16'h0FF0, 4'd5, 1'b1);
    idle(3, 1'b1);

    // backpressure: fill FIFO behind a held response, fourth push refused
    cycle(1'b1, OP_ADD, 16'h0001, 16'h0001, 4'd8,  1'b0);
    cycle(1'b1, OP_ADD, 16'h0002, 16'h0002, 4'd9,  1'b0);
    cycle(1'b1, OP_ADD, 16'h0003, 16'h0003, 4'd10, 1'b0);
    cycle(1'b1, OP_ADD, 16'h0004, 16'h0004, 4'd11, 1'b0);
    idle(2, 1'b0);
    idle(4, 1'b1);

    // illegal op followed by a legal one
    cycle(1'b1, 3'd6,   16'h1234, 16'h5678, 4'd7, 1'b1);
    cycle(1'b1, OP_ADD, 16'h1234, 16'h1111, 4'd6, 1'b1);
    idle(3, 1'b1);

    // reset with two queued commands and a held response
    cycle(1'b1, OP_OR,  16'h00FF, 16'hFF00, 4'd12, 1'b0);
    cycle(1'b1, OP_AND, 16'hFFFF, 16'h1234, 4'd13, 1'b0);
    cycle(1'b1, OP_ADD, 16'h0010, 16'h0020, 4'd14, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk_reset("mid");
    model_clear();
    @(posedge clk);
    #1 rst_n = 1'b1;
    idle(4, 1'b1);
    cycle(1'b1, OP_SUB, 16'h0009, 16'h0002, 4'd15, 1'b1);
    idle(3, 1'b1);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      rv  = ($urandom_range(0, 3) != 0);
      rop = 3'($urandom_range(0, 7));
      ra  = pick_operand();
      rb  = pick_operand();
      rr  = ($urandom_range(0, 3) != 0);
      cycle(rv, rop, ra, rb, 4'($urandom), rr);
    end
    idle(6, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule

// File: doc/alu_issue_ctrl.md
# alu_issue_ctrl

Command-side controller for the 16-bit combinational ALU: it accepts operation requests from the decode stage over a valid/ready handshake, buffers up to two in a small FIFO, and drives the ALU operand and opcode ports from the FIFO head. It also registers the ALU result and flags into a response register with its own valid/ready handshake. It sits between decode and writeback and is the only driver of the ALU's X, Y and opcode inputs.

## Interface
- DEPTH, 2, command FIFO entries (power of two, ≥2)
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  FIFO not full
- cmd_op  in  3  0 AND, 1 OR, 2 ADD, 3 SUB, 4 SLT, 5–7 illegal
- cmd_a, cmd_b  in  16  operands
- cmd_tag  in  4  caller tag, returned with response
- alu_x, alu_y  out  16  ALU operands (FIFO head, zero when empty)
- alu_opcode  out  3  AND 000, OR 001, ADD 010, SUB 110, SLT 110
- alu_out  in  16  ALU result
- alu_cout, alu_v, alu_lt, alu_eq, alu_gt  in  1  ALU flags
- rsp_valid  out  1  response held
- rsp_ready  in  1  consumer accepts
- rsp_data  out  16  result
- rsp_flags  out  5  {V, cout, lt, eq, gt}
- rsp_tag  out  4  tag of command
- rsp_err  out  1  illegal op (or trap, see Configuration)

## Operation
- FIFO write on cmd_valid && cmd_ready; read ("issue") when head valid and response register free or being drained this cycle (rsp_ready && rsp_valid).
- ALU ports are driven combinationally from the FIFO head; the issue edge captures alu_out and flags into rsp_*.
- SLT: rsp_data = {15'b0, alu_lt}; all flags still captured.
- Illegal op: no ALU dependence, rsp_data = 0, rsp_flags = 0, rsp_err = 1, tag returned.
- FSM states:
  - IDLE: FIFO empty, rsp empty
  - RUN: issuing or rsp draining
  - STALL: rsp_valid && !rsp_ready with head valid
  - Transitions: IDLE→RUN on first write; RUN→STALL when rsp blocked and head valid; STALL→RUN on rsp_ready; RUN→IDLE when FIFO empty and rsp drained.
- Simultaneous write and issue while full: write refused (cmd_ready is registered from count, not bypassed).
- Simultaneous write and issue while count = 1: count unchanged.
- Pointers wrap modulo DEPTH; count width is log2(DEPTH)+1.

## Timing
- Reset (async assert, sync-released internally by clk edge): cmd_ready = 1, rsp_valid = 0, rsp_data = 0, rsp_flags = 0, rsp_tag = 0, rsp_err = 0, alu_x/alu_y = 0, alu_opcode = 000, FIFO empty, state IDLE.
- Latency: command accepted at edge k → issued at edge k+1 → rsp_valid high after edge k+1.
- Throughput: one result per cycle with rsp_ready held high.
- rsp_* stable while rsp_valid && !rsp_ready.
- cmd_ready low exactly when count = DEPTH.
- Reset mid-operation: FIFO contents and pending response discarded immediately; no response emitted for them.

## Configuration
- ALU_OVF_TRAP_EN defined:
  - ADD/SUB with alu_v = 1 sets rsp_err = 1 and forces rsp_data = 0.
  - Sets a sticky internal trap bit that drops cmd_ready until reset; the FIFO keeps draining.
- Undefined: overflow reported only via rsp_flags[4]; rsp_data carries the wrapped sum; cmd_ready unaffected.

## Test plan
- ADD a=0x0005 b=0x0003 tag=1, rsp_ready=1 → rsp_valid one edge after issue, data 0x0008, flags cout=0 V=0, tag 1.
- SUB a=0x7FFF b=0xFFFF → data 0x8000, V=1. With ALU_OVF_TRAP_EN: data 0, rsp_err=1, cmd_ready stays 0 afterwards.
- SLT a=0x0002 b=0x0009 → data 0x0001, lt=1, eq=0; then AND 0xF0F0&0x0FF0 → 0x00F0; then OR → 0xFFF0.
- rsp_ready=0, push 3 commands → first response held stable; FIFO holds 2, cmd_ready=0; release rsp_ready → three responses in order, one per cycle.
- cmd_op=6 tag=7 → rsp_err=1, data 0, tag 7; the next legal command is unaffected.
- Assert rst_n=0 with 2 commands queued and rsp_valid=1 → all outputs take reset values asynchronously; no stale response appears after release.
